// File: rtl/whack_round_controller.sv
// rtl/whack_round_controller.sv - whack-an-engineer round sequencer: mole timing, hit/miss judging, score and lives
module whack_round_controller #(
  parameter int UP_CYCLES  = 8,
  parameter int GAP_CYCLES = 4,
  parameter int LIVES      = 3,
  parameter int SCORE_W    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         key_code,
  input  logic               key_valid,
  output logic [2:0]         mole_id,
  output logic               mole_up,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               game_over
);

  localparam int TMAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_UP   = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t             state_q;
  logic [TW-1:0]      timer_q;
  logic [15:0]        lfsr_q;
  logic [15:0]        lfsr_d;
  logic               key_prev_q;
  logic [2:0]         mole_id_q;
  logic               mole_up_q;
  logic               hit_q;
  logic               miss_q;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_inc;
  logic [2:0]         lives_q;
  logic [2:0]         lives_dec;
  logic               game_over_q;
  logic               key_edge;
  logic [2:0]         hole;
  logic               up_timeout;
  logic               gap_done;

  // Next LFSR value, key rising edge, hole pick and saturating/decrementing helpers
  always_comb begin
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    key_edge   = key_valid & ~key_prev_q;
    hole       = (lfsr_q[2:0] < 3'd5) ? (lfsr_q[2:0] + 3'd1) : (lfsr_q[2:0] - 3'd4);
    score_inc  = (score_q == {SCORE_W{1'b1}}) ? score_q : (score_q + {{(SCORE_W-1){1'b0}}, 1'b1});
    lives_dec  = lives_q - 3'd1;
    up_timeout = (timer_q == TW'(UP_CYCLES - 1));
    gap_done   = (timer_q == TW'(GAP_CYCLES - 1));
  end

  // Round state machine with all outputs registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      lfsr_q      <= 16'hACE1;
      key_prev_q  <= 1'b0;
      mole_id_q   <= 3'd0;
      mole_up_q   <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      score_q     <= '0;
      lives_q     <= 3'(LIVES);
      game_over_q <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      key_prev_q <= key_valid;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          // Key edges here are simply dropped
          if (start) begin
            score_q     <= '0;
            lives_q     <= 3'(LIVES);
            timer_q     <= '0;
            game_over_q <= 1'b0;
            state_q     <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_done) begin
            mole_id_q <= hole;
            mole_up_q <= 1'b1;
            timer_q   <= '0;
            state_q   <= S_UP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_UP: begin
          // A key edge takes priority over a timeout landing in the same cycle
          if (key_edge && (key_code == {1'b0, mole_id_q})) begin
            hit_q     <= 1'b1;
            score_q   <= score_inc;
            mole_id_q <= 3'd0;
            mole_up_q <= 1'b0;
            timer_q   <= '0;
            state_q   <= S_GAP;
          end else if (key_edge || up_timeout) begin
            miss_q    <= 1'b1;
            lives_q   <= lives_dec;
            mole_id_q <= 3'd0;
            mole_up_q <= 1'b0;
            timer_q   <= '0;
            if (lives_dec == 3'd0) begin
              game_over_q <= 1'b1;
              state_q     <= S_OVER;
            end else begin
              state_q <= S_GAP;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mole_id   = mole_id_q;
  assign mole_up   = mole_up_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_whack_round_controller.sv
// tb/tb_whack_round_controller.sv - self-checking bench for whack_round_controller
module tb_whack_round_controller;

  localparam int UPC = 8;
  localparam int GPC = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       key_valid = 1'b0;

  logic [2:0] mole_id, mole_id2;
  logic       mole_up, mole_up2, hit, hit2, miss, miss2, game_over, game_over2;
  logic [7:0] score;
  logic [1:0] score2;
  logic [2:0] lives, lives2;

  int total = 0;
  int bad   = 0;

  whack_round_controller #(.UP_CYCLES(UPC), .GAP_CYCLES(GPC), .LIVES(3), .SCORE_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .key_code(key_code), .key_valid(key_valid),
    .mole_id(mole_id), .mole_up(mole_up), .hit(hit), .miss(miss), .score(score),
    .lives(lives), .game_over(game_over)
  );

  whack_round_controller #(.UP_CYCLES(UPC), .GAP_CYCLES(GPC), .LIVES(3), .SCORE_W(2)) dut2 (
    .clock(clock), .reset(reset), .start(start), .key_code(key_code), .key_valid(key_valid),
    .mole_id(mole_id2), .mole_up(mole_up2), .hit(hit2), .miss(miss2), .score(score2),
    .lives(lives2), .game_over(game_over2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int   id;
    logic up;
    logic ht;
    logic ms;
    int   s8;
    int   s2;
    int   lv;
    logic go;
  } exp_t;

  exp_t sb[$];

  typedef enum int {M_IDLE, M_GAP, M_UP, M_OVER} mstate_t;
  mstate_t     ms_st = M_IDLE;
  int          m_t = 0;
  logic [15:0] m_l = 16'hACE1;
  logic        m_k = 1'b0;
  int          m_id = 0;
  logic        m_up = 1'b0, m_hit = 1'b0, m_miss = 1'b0, m_go = 1'b0;
  int          m_score = 0;
  int          m_lives = 3;

  always @(posedge clock) begin
    logic [15:0] cur;
    logic        edge_k;
    int          code;
    exp_t        e;
    edge_k = key_valid & ~m_k;
    code   = int'(key_code);
    m_hit  = 1'b0;
    m_miss = 1'b0;
    if (reset) begin
      ms_st = M_IDLE; m_t = 0; m_l = 16'hACE1; m_k = 1'b0; m_id = 0;
      m_up = 1'b0; m_go = 1'b0; m_score = 0; m_lives = 3;
    end else begin
      cur = m_l;
      m_l = {m_l[14:0], ^(m_l & 16'hB400)};
      m_k = key_valid;
      case (ms_st)
        M_IDLE, M_OVER: if (start) begin
          m_score = 0; m_lives = 3; m_t = 0; m_go = 1'b0; ms_st = M_GAP;
        end
        M_GAP: if (m_t == GPC - 1) begin
          m_id = (int'(cur[2:0]) % 5) + 1; m_up = 1'b1; m_t = 0; ms_st = M_UP;
        end else m_t++;
        M_UP: begin
          if (edge_k && code == m_id) begin
            m_hit = 1'b1; m_score++; m_id = 0; m_up = 1'b0; m_t = 0; ms_st = M_GAP;
          end else if (edge_k || m_t == UPC - 1) begin
            m_miss = 1'b1; m_lives--; m_id = 0; m_up = 1'b0; m_t = 0;
            m_go  = (m_lives == 0);
            ms_st = (m_lives == 0) ? M_OVER : M_GAP;
          end else m_t++;
        end
        default: ms_st = M_IDLE;
      endcase
    end
    e.id = m_id; e.up = m_up; e.ht = m_hit; e.ms = m_miss;
    e.s8 = (m_score > 255) ? 255 : m_score;
    e.s2 = (m_score > 3) ? 3 : m_score;
    e.lv = m_lives; e.go = m_go;
    sb.push_back(e);
  end

  // Pop one expectation per cycle and compare both instances away from the edge
  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_mole_id", int'(mole_id), e.id);
      chk("sb_mole_up", int'(mole_up), int'(e.up));
      chk("sb_hit", int'(hit), int'(e.ht));
      chk("sb_miss", int'(miss), int'(e.ms));
      chk("sb_score8", int'(score), e.s8);
      chk("sb_score2", int'(score2), e.s2);
      chk("sb_lives", int'(lives), e.lv);
      chk("sb_game_over", int'(game_over), int'(e.go));
      chk("sb_mole_id2", int'(mole_id2), e.id);
      chk("sb_lives2", int'(lives2), e.lv);
      chk("sb_hit_miss_excl", int'(hit & miss), 0);
      if (mole_up) chk("mole_range", int'(mole_id >= 3'd1 && mole_id <= 3'd5), 1);
      if (mole_up2 != mole_up || hit2 != hit || miss2 != miss || game_over2 != game_over)
        chk("dut2_agree", 0, 1);
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    int   delay;   // cycles into UP at which the key edge is judged
    int   ksel;    // 0 correct, 1 wrong, 2 key_code 0
    logic e_hit;
    logic e_miss;
    int   d_score;
    int   d_lives;
  } vec_t;

  vec_t vecs[6];
  int   exp_score;
  int   exp_lives;

  task automatic wait_up();
    for (int n = 0; n < 60; n++) begin
      if (mole_up) break;
      @(negedge clock);
    end
    if (!mole_up) chk("wait_up_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    int saw_hit;
    vecs[0] = '{3, 0, 1'b1, 1'b0, 1, 0};
    vecs[1] = '{2, 1, 1'b0, 1'b1, 0, -1};
    vecs[2] = '{7, 0, 1'b1, 1'b0, 1, 0};
    vecs[3] = '{1, 2, 1'b0, 1'b1, 0, -1};
    vecs[4] = '{0, 0, 1'b1, 1'b0, 1, 0};
    vecs[5] = '{4, 0, 1'b1, 1'b0, 1, 0};

    repeat (3) @(negedge clock);
    chk("rst_mole_id", int'(mole_id), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_score", int'(score), 0);
    chk("rst_game_over", int'(game_over), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_no_mole", int'(mole_up), 0);

    pulse_start();
    exp_score = 0;
    exp_lives = 3;

    for (int i = 0; i < 6; i++) begin
      wait_up();
      repeat (vecs[i].delay) @(negedge clock);
      case (vecs[i].ksel)
        0:       key_code = 4'(m_id);
        1:       key_code = 4'((m_id % 5) + 1);
        default: key_code = 4'd0;
      endcase
      key_valid = 1'b1;
      @(negedge clock);
      exp_score += vecs[i].d_score;
      exp_lives += vecs[i].d_lives;
      chk("vec_hit", int'(hit), int'(vecs[i].e_hit));
      chk("vec_miss", int'(miss), int'(vecs[i].e_miss));
      chk("vec_mole_down", int'(mole_up), 0);
      chk("vec_score8", int'(score), exp_score);
      chk("vec_score2", int'(score2), (exp_score > 3) ? 3 : exp_score);
      chk("vec_lives", int'(lives), exp_lives);
      key_valid = 1'b0;
      if (i == 0) begin
        cnt = 0;
        while (!mole_up && cnt < 20) begin
          @(negedge clock);
          cnt++;
        end
        chk("gap_len_after_hit", cnt, GPC);
      end
    end

    // Key held high from a hit through GAP into the next UP: no further event
    wait_up();
    repeat (2) @(negedge clock);
    key_code  = 4'(m_id);
    key_valid = 1'b1;
    @(negedge clock);
    chk("held_first_hit", int'(hit), 1);
    exp_score++;
    wait_up();
    key_code = 4'(m_id);
    cnt = 1;
    saw_hit = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (hit) saw_hit = 1;
      if (!mole_up) break;
      cnt++;
    end
    chk("held_no_hit", saw_hit, 0);
    chk("held_up_len", cnt, UPC);
    chk("held_timeout_miss", int'(miss), 1);
    chk("over_lives", int'(lives), 0);
    chk("over_flag", int'(game_over), 1);
    chk("over_mole_id", int'(mole_id), 0);
    key_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("over_score_held", int'(score), exp_score);
    chk("over_still", int'(game_over), 1);

    // Restart, then three unanswered rounds; start pulses in GAP/UP are ignored
    pulse_start();
    chk("restart_lives", int'(lives), 3);
    chk("restart_score", int'(score), 0);
    chk("restart_go", int'(game_over), 0);
    for (int r = 0; r < 3; r++) begin
      if (r == 0) pulse_start();
      wait_up();
      cnt = 1;
      for (int n = 0; n < 20; n++) begin
        start = (r == 1) && (cnt == 1);
        @(negedge clock);
        start = 1'b0;
        if (!mole_up) break;
        cnt++;
      end
      chk("timeout_up_len", cnt, UPC);
      chk("timeout_miss", int'(miss), 1);
      chk("timeout_lives", int'(lives), 2 - r);
    end
    chk("timeout_over", int'(game_over), 1);
    chk("timeout_mole_id", int'(mole_id), 0);
    pulse_start();
    chk("restart2_lives", int'(lives), 3);
    chk("restart2_score", int'(score), 0);

    // Reset while a mole is up
    wait_up();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_mole_up", int'(mole_up), 0);
    chk("midrst_mole_id", int'(mole_id), 0);
    chk("midrst_lives", int'(lives), 3);
    chk("midrst_score", int'(score), 0);
    chk("midrst_hit_miss", int'(hit | miss), 0);
    reset = 1'b0;
    saw_hit = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clock);
      if (mole_up) saw_hit = 1;
    end
    chk("midrst_idle", saw_hit, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/whack_round_controller.md
# whack_round_controller

Game-round sequencer for whack-an-engineer. It sits between the keyboard decoder (key code 1..5 plus a key-pressed level) and the score/graphics logic. It picks which of five holes is active with an LFSR, times each pop-up, judges every keypress as a hit or a miss, and tracks score and lives until the game ends.

## Interface
- UP_CYCLES, default 8: clock cycles a mole stays up; must be ≥2.
- GAP_CYCLES, default 4: clock cycles between moles with no mole up; must be ≥1.
- LIVES, default 3: starting lives; range 1..7.
- SCORE_W, default 8: score width.

- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high.
- start  in  1  start/restart request; sampled every cycle, honoured only in IDLE or OVER.
- key_code  in  4  decoded key, 1..5 = holes; 0 and 6..15 are never a hit.
- key_valid  in  1  key-pressed level from the decoder; only its rising edge counts.
- mole_id  out  3  active hole 1..5 while UP, 0 otherwise.
- mole_up  out  1  high exactly while in UP.
- hit  out  1  one-cycle pulse on a correct key.
- miss  out  1  one-cycle pulse on a wrong key or a timeout.
- score  out  SCORE_W  hit count, saturating at 2^SCORE_W−1.
- lives  out  3  remaining lives.
- game_over  out  1  high while in OVER.

## Operation
- States: IDLE, GAP, UP, OVER. Reset sends the block to IDLE from any state, mid-game included.
- Reset values:
  - mole_id=0, mole_up=0, hit=0, miss=0, score=0, game_over=0.
  - lives=LIVES.
  - timer=0.
  - key_valid_d=0.
  - lfsr=16'hACE1.
- LFSR: 16-bit Fibonacci.
  - Advances every cycle in every state except during reset: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Hole selection: idx=lfsr[2:0]; hole = idx<5 ? idx+1 : idx−4.
- Key event: edge = key_valid & ~key_valid_d, where key_valid_d is registered every cycle. Edges in IDLE, GAP or OVER are discarded, not queued.
- IDLE: start → score=0, lives=LIVES, timer=0, go to GAP.
- GAP:
  - timer counts up from 0.
  - At timer==GAP_CYCLES−1: latch mole_id=hole from the current lfsr, timer=0, go to UP.
- UP: timer counts up from 0.
  - edge and key_code==mole_id → hit=1, score+1 (saturating), go to GAP.
  - edge and key_code≠mole_id → miss=1, lives−1.
  - No edge and timer==UP_CYCLES−1 → miss=1, lives−1.
  - After either miss: go to OVER if the new lives value is 0, else go to GAP.
  - Any exit from UP sets mole_id=0 and timer=0.
  - Edge and timeout in the same cycle: the key is judged; the timeout is ignored.
- OVER: game_over=1 and score is held. start → same action as start in IDLE, with game_over cleared.
- start is ignored in GAP and UP.
- hit and miss are never high together.

## Timing
- All outputs are registered and change only on posedge clock.
- An edge sampled at posedge n is judged at posedge n. hit/miss, score, lives, mole_up and state all update together after posedge n.
- Round shape with no keypress:
  - mole_up is high for exactly UP_CYCLES cycles.
  - miss rises in the cycle mole_up falls.
  - The next mole_up rises GAP_CYCLES cycles later.
- start at posedge n: the first mole_up rises after posedge n+GAP_CYCLES.
- key_valid held high across several rounds produces one edge only.

## Test plan
- Hit (UP_CYCLES=8, GAP_CYCLES=4): reset, start, wait for mole_up, drive key_code=mole_id with a key_valid rising edge 3 cycles in. Required: hit for 1 cycle, score 0→1, mole_up low the same cycle, next mole_up 4 cycles later.
- Wrong key: in UP, drive key_code=(mole_id mod 5)+1 with an edge. Required: miss pulse, lives 3→2, score unchanged, then GAP.
- Timeout to game over: start, never press. Required:
  - Three misses, each in the cycle mole_up falls after 8 high cycles.
  - lives 3→2→1→0, then game_over=1, mole_id=0.
  - start restarts with lives=3, score=0.
- Simultaneous and edge rules:
  - Correct key edge in the final UP cycle → hit, no miss.
  - key_valid held high from GAP into UP → no event.
  - key_code=0 with an edge in UP → miss.
- Saturation and determinism (SCORE_W=2):
  - Four hits → score stays 3.
  - mole_id sequence matches a bench LFSR model seeded 16'hACE1 from reset release.
  - mole_id always in 1..5 while UP.
- Reset mid-UP and start ignored: assert reset while mole_up=1 → all outputs return to reset values the next cycle, state IDLE. Pulse start in GAP/UP → no effect on score or lives.
